apb_mtimer: RTL and testbench

- RISC-V machine-timer peripheral; APB slave alongside the RAM on the core's APB bus.
- Holds 64-bit mtime and mtimecmp registers and drives mtimer_int into core_top.
- An external address decoder generates psel; this block decodes only paddr[3:0].

---
 rtl/apb_mtimer.sv | 78 +++++++
 tb/tb_apb_mtimer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_mtimer.sv
// apb_mtimer: RISC-V machine timer APB slave; define MTIMER_READ_LATCH_EN to latch mtime[63:32] on 0x0 reads
module apb_mtimer #(
    parameter int unsigned PRESCALE     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    output logic        pready,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pwstrb,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        mtimer_int
);
    logic        access, ok, wr, rd, tick, unused;
    logic [1:0]  sel;
    logic [15:0] cnt;
    logic [31:0] hi_rd;
    logic [63:0] mtime, mtimecmp, mtime_inc, mtime_next, mtimecmp_next;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    // Outputs are gated by rst_n so a reset edge mid-transfer shows reset values
    assign access    = rst_n & psel & penable;
    assign pready    = access;
    assign pslverr   = access & (paddr[1:0] != 2'b00);
    assign ok        = access & ~pslverr;
    assign wr        = ok & pwrite;
    assign rd        = ok & ~pwrite;
    assign sel       = paddr[3:2];
    assign unused    = ^paddr[31:4];
    assign tick      = cnt == 16'(PRESCALE - 1);
    assign mtime_inc = mtime + 64'(tick);

    assign mtime_next = {wr && sel == 2'd1 ? merge(mtime_inc[63:32], pwdata, pwstrb) : mtime_inc[63:32],
                         wr && sel == 2'd0 ? merge(mtime_inc[31:0], pwdata, pwstrb) : mtime_inc[31:0]};
    assign mtimecmp_next = {wr && sel == 2'd3 ? merge(mtimecmp[63:32], pwdata, pwstrb) : mtimecmp[63:32],
                            wr && sel == 2'd2 ? merge(mtimecmp[31:0], pwdata, pwstrb) : mtimecmp[31:0]};

    assign prdata = !ok       ? 32'd0 :
                    sel == 0  ? mtime[31:0] :
                    sel == 1  ? hi_rd :
                    sel == 2  ? mtimecmp[31:0] : mtimecmp[63:32];

`ifdef MTIMER_READ_LATCH_EN
    logic [31:0] shadow;
    always_ff @(posedge clk)
        if (!rst_n) shadow <= '0;
        else if (rd && sel == 2'd0) shadow <= mtime[63:32];
        else if (wr && sel == 2'd1) shadow <= merge(shadow, pwdata, pwstrb);
    assign hi_rd = shadow;
`else
    logic unused_rd;
    assign unused_rd = rd;
    assign hi_rd = mtime[63:32];
`endif

    always_ff @(posedge clk)
        if (!rst_n) begin
            cnt        <= '0;
            mtime      <= '0;
            mtimecmp   <= MTIMECMP_RST;
            mtimer_int <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 16'd1;
            mtime      <= mtime_next;
            mtimecmp   <= mtimecmp_next;
            mtimer_int <= mtime_next >= mtimecmp_next;
        end
endmodule

// File: tb/tb_apb_mtimer.sv
// tb_apb_mtimer: scoreboard bench running apb_mtimer at PRESCALE 1 and 4 against a reference model
module tb_apb_mtimer;
    localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int DIV [2] = '{1, 4};

    logic        clk = 0, rst_n = 0, psel = 0, penable = 0, pwrite = 0;
    logic [31:0] paddr = 0, pwdata = 0;
    logic [3:0]  pwstrb = 0;
    logic        pready [2], pslverr [2], mtimer_int [2];
    logic [31:0] prdata [2];
    int nchk = 0, nfail = 0;

    typedef struct { logic err; logic [1:0][31:0] d; } exp_t;
    exp_t sbq [$];

    logic [63:0] m_time [2], m_cmp [2];
    logic [31:0] m_shd [2];
    logic        m_int [2];
    longint unsigned nedge = 0;

    always #5 clk = ~clk;

    apb_mtimer #(.PRESCALE(1)) u1 (.clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pready(pready[0]),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb), .prdata(prdata[0]),
        .pslverr(pslverr[0]), .mtimer_int(mtimer_int[0]));
    apb_mtimer #(.PRESCALE(4)) u4 (.clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pready(pready[1]),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb), .prdata(prdata[1]),
        .pslverr(pslverr[1]), .mtimer_int(mtimer_int[1]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mtime counts completed edges since reset divided by the prescale, then writes overlay bytes
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [63:0] t, c;
            logic [31:0] s;
            t = m_time[k] + 64'(((nedge + 1) % longint'(DIV[k])) == 0);
            c = m_cmp[k];
            s = m_shd[k];
            if (psel && penable && paddr[1:0] == 2'b00) begin
                if (pwrite) begin
                    for (int i = 0; i < 4; i++)
                        if (pwstrb[i]) begin
                            if (paddr[3]) c[(paddr[2] ? 32 : 0) + 8*i +: 8] = pwdata[8*i +: 8];
                            else          t[(paddr[2] ? 32 : 0) + 8*i +: 8] = pwdata[8*i +: 8];
                            if (paddr[3:2] == 2'd1) s[8*i +: 8] = pwdata[8*i +: 8];
                        end
                end else if (paddr[3:2] == 2'd0) s = m_time[k][63:32];
            end
            if (!rst_n) begin
                t = 0;
                c = CMP_RST;
                s = 0;
            end
            m_time[k] <= t;
            m_cmp[k]  <= c;
            m_shd[k]  <= s;
            m_int[k]  <= rst_n && (t >= c);
        end
        nedge <= rst_n ? nedge + 1 : 0;
    end

    function automatic logic [31:0] rdval(input int k, input logic [3:0] a);
        logic [63:0] r;
        r = a[3] ? m_cmp[k] : m_time[k];
        if (a[1:0] != 2'b00) return 32'd0;
`ifdef MTIMER_READ_LATCH_EN
        if (a[3:2] == 2'd1) return m_shd[k];
`endif
        return a[2] ? r[63:32] : r[31:0];
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            chk("pready", {63'd0, pready[k]}, {63'd0, rst_n & psel & penable});
            chk("mtimer_int", {63'd0, mtimer_int[k]}, {63'd0, m_int[k]});
            if (!(rst_n && psel && penable)) begin
                chk("prdata_idle", {32'd0, prdata[k]}, 64'd0);
                chk("pslverr_idle", {63'd0, pslverr[k]}, 64'd0);
            end
        end
        if (rst_n && psel && penable) begin
            if (sbq.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL sb_underflow: transfer seen with no expectation at %0t", $time);
            end else begin
                e = sbq.pop_front();
                for (int k = 0; k < 2; k++) begin
                    chk("prdata", {32'd0, prdata[k]}, {32'd0, e.d[k]});
                    chk("pslverr", {63'd0, pslverr[k]}, {63'd0, e.err});
                end
            end
        end
    end

    task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] r0, output logic [31:0] r1, output logic er);
        exp_t e;
        @(posedge clk); #1;
        psel = 1; penable = 0; paddr = a; pwrite = w; pwdata = d; pwstrb = s;
        @(posedge clk); #1;
        penable = 1;
        e.err = a[1:0] != 2'b00;
        for (int k = 0; k < 2; k++) e.d[k] = rdval(k, a[3:0]);
        sbq.push_back(e);
        #2;
        r0 = prdata[0];
        r1 = prdata[1];
        er = pslverr[0];
        @(posedge clk); #1;
        psel = 0; penable = 0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst_n = 0;
        repeat (n) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r0, r1;
        logic er;
        do_reset(3);
        chk("rst_int", {63'd0, mtimer_int[0]}, 64'd0);
        repeat (10) @(posedge clk);
        apb(32'h0, 0, 0, 0, r0, r1, er);
        chk("idle_lo_p1", {32'd0, r0}, 64'd12);
        chk("idle_lo_p4", {32'd0, r1}, 64'd3);
        apb(32'h4, 0, 0, 0, r0, r1, er);
        chk("idle_hi", {32'd0, r0}, 64'd0);

        apb(32'h4, 1, 32'h0, 4'hF, r0, r1, er);
        apb(32'h0, 1, 32'hFFFF_FFFE, 4'hF, r0, r1, er);
        repeat (3) @(posedge clk);
        apb(32'h4, 0, 0, 0, r0, r1, er);
        chk("carry_hi", {32'd0, r0}, 64'd1);
        apb(32'h0, 0, 0, 0, r0, r1, er);
        chk("carry_lo_small", {63'd0, r0 < 32'd16}, 64'd1);

        apb(32'h4, 1, 32'h0, 4'hF, r0, r1, er);
        apb(32'h0, 1, 32'h0, 4'hF, r0, r1, er);
        apb(32'hC, 1, 32'h0, 4'hF, r0, r1, er);
        apb(32'h8, 1, 32'd100, 4'hF, r0, r1, er);
        chk("int_low_before", {63'd0, mtimer_int[0]}, 64'd0);
        for (int i = 0; i < 200 && !mtimer_int[0]; i++) @(posedge clk);
        #1 chk("int_rise", {63'd0, mtimer_int[0]}, 64'd1);
        apb(32'hC, 1, 32'h1, 4'hF, r0, r1, er);
        chk("int_drop", {63'd0, mtimer_int[0]}, 64'd0);

        apb(32'h8, 1, 32'hFFFF_FFFF, 4'hF, r0, r1, er);
        apb(32'h8, 1, 32'hAABB_CCDD, 4'b0101, r0, r1, er);
        apb(32'h8, 0, 0, 0, r0, r1, er);
        chk("strobe_cmp", {32'd0, r0}, 64'hFFBB_FFDD);
        apb(32'h9, 1, 32'h1234_5678, 4'hF, r0, r1, er);
        chk("err_wr", {63'd0, er}, 64'd1);
        apb(32'h9, 0, 0, 0, r0, r1, er);
        chk("err_rd_data", {32'd0, r0}, 64'd0);
        apb(32'h8, 0, 0, 0, r0, r1, er);
        chk("err_unchanged", {32'd0, r0}, 64'hFFBB_FFDD);

        @(posedge clk); #1;
        psel = 1; penable = 0; paddr = 0; pwrite = 1; pwdata = 32'h5555_5555; pwstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1; rst_n = 0;
        #1;
        chk("rst_pready_p1", {63'd0, pready[0]}, 64'd0);
        chk("rst_pready_p4", {63'd0, pready[1]}, 64'd0);
        @(posedge clk); #1;
        psel = 0; penable = 0; rst_n = 1;
        repeat (40) @(posedge clk);
        apb(32'h0, 0, 0, 0, r0, r1, er);
        chk("p1_after_rst", {32'd0, r0}, 64'd42);
        chk("p4_40cyc", {32'd0, r1}, 64'd10);
        apb(32'h8, 0, 0, 0, r0, r1, er);
        chk("cmp_rst_lo", {32'd0, r0}, 64'hFFFF_FFFF);

        apb(32'h4, 1, 32'h0, 4'hF, r0, r1, er);
        apb(32'h0, 1, 32'hFFFF_FFFD, 4'hF, r0, r1, er);
        apb(32'h0, 0, 0, 0, r0, r1, er);
        chk("latch_lo", {32'd0, r0}, 64'hFFFF_FFFF);
        apb(32'h4, 0, 0, 0, r0, r1, er);
`ifdef MTIMER_READ_LATCH_EN
        chk("latch_hi", {32'd0, r0}, 64'd0);
`else
        chk("live_hi", {32'd0, r0}, 64'd1);
`endif

        for (int n = 0; n < 150; n++) begin
            apb(32'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), r0, r1, er);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        nchk++;
        if (sbq.size() != 0) begin
            nfail++;
            $display("FAIL sb_drain: %0d expectations left, 0 required", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
